// File: rtl/filt_pkg.sv
// rtl/filt_pkg.sv - shared filter FSM states, Q-format shift and saturation bounds
package filt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_SAT  = 2'd2,
    ST_OUT  = 2'd3
  } filt_state_t;

  // Coefficients are Q1.(cw-1), so a product is rescaled by cw-1 bits
  function automatic int q_shift(input int coeff_width);
    return coeff_width - 1;
  endfunction

  function automatic longint sat_max(input int data_width);
    return (longint'(1) <<< (data_width - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int data_width);
    return -(longint'(1) <<< (data_width - 1));
  endfunction

endpackage

// File: rtl/signed_mac.sv
// rtl/signed_mac.sv - single-register signed multiply-accumulate with add/subtract select
module signed_mac #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          en,
  input  logic                          sub,
  input  logic signed [DATA_WIDTH-1:0]  operand,
  input  logic signed [COEFF_WIDTH-1:0] coeff,
  output logic signed [ACC_WIDTH-1:0]   acc
);

  localparam int PW = DATA_WIDTH + COEFF_WIDTH;

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;

  // Low PW bits of the widened product are the exact two's-complement result
  always_comb begin
    prod     = $signed({{COEFF_WIDTH{operand[DATA_WIDTH-1]}}, operand})
             * $signed({{DATA_WIDTH{coeff[COEFF_WIDTH-1]}}, coeff});
    prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sub ? acc - prod_ext : acc + prod_ext;
    end
  end

endmodule

// File: rtl/iir_allpole_3rd_order_mac.sv
// rtl/iir_allpole_3rd_order_mac.sv - 3rd-order all-pole IIR on one time-shared MAC
module iir_allpole_3rd_order_mac
  import filt_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr_state,
  input  logic signed [DATA_WIDTH-1:0]  x,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [COEFF_WIDTH-1:0] g0,
  input  logic signed [COEFF_WIDTH-1:0] a1,
  input  logic signed [COEFF_WIDTH-1:0] a2,
  input  logic signed [COEFF_WIDTH-1:0] a3,
  output logic signed [DATA_WIDTH-1:0]  y,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          sat_flag
);

  localparam int QS = q_shift(COEFF_WIDTH);
  localparam logic signed [ACC_WIDTH-1:0]  ACC_MAX = ACC_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0]  ACC_MIN = ACC_WIDTH'(sat_min(DATA_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] Y_MAX   = DATA_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] Y_MIN   = DATA_WIDTH'(sat_min(DATA_WIDTH));

  filt_state_t                   state;
  logic [1:0]                    tap;
  logic signed [DATA_WIDTH-1:0]  x_s, y1, y2, y3;
  logic signed [COEFF_WIDTH-1:0] g0_s, a1_s, a2_s, a3_s;

  logic                          accept;
  logic signed [DATA_WIDTH-1:0]  mac_operand;
  logic signed [COEFF_WIDTH-1:0] mac_coeff;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [ACC_WIDTH-1:0]   acc_shift;
  logic signed [DATA_WIDTH-1:0]  y_sat;
  logic                          clamped;

  assign accept = in_ready && in_valid && !clr_state;

  always_comb begin
    mac_operand = x_s;
    mac_coeff   = g0_s;
    case (tap)
      2'd1:    begin mac_operand = y1; mac_coeff = a1_s; end
      2'd2:    begin mac_operand = y2; mac_coeff = a2_s; end
      2'd3:    begin mac_operand = y3; mac_coeff = a3_s; end
      default: begin mac_operand = x_s; mac_coeff = g0_s; end
    endcase
  end

  // Feedback taps subtract their product rather than negating the coefficient,
  // so a coefficient of -2^(CW-1) stays exact
  signed_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEFF_WIDTH(COEFF_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept || clr_state),
    .en     (state == ST_MAC),
    .sub    (tap != 2'd0),
    .operand(mac_operand),
    .coeff  (mac_coeff),
    .acc    (acc)
  );

  always_comb begin
    acc_shift = acc >>> QS;
    clamped   = 1'b0;
    y_sat     = acc_shift[DATA_WIDTH-1:0];
    if (acc_shift > ACC_MAX) begin
      y_sat   = Y_MAX;
      clamped = 1'b1;
    end else if (acc_shift < ACC_MIN) begin
      y_sat   = Y_MIN;
      clamped = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tap       <= 2'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
      y         <= '0;
      y1        <= '0;
      y2        <= '0;
      y3        <= '0;
      x_s       <= '0;
      g0_s      <= '0;
      a1_s      <= '0;
      a2_s      <= '0;
      a3_s      <= '0;
    end else if (clr_state) begin
      state     <= ST_IDLE;
      tap       <= 2'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
      y         <= '0;
      y1        <= '0;
      y2        <= '0;
      y3        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            x_s      <= x;
            g0_s     <= g0;
            a1_s     <= a1;
            a2_s     <= a2;
            a3_s     <= a3;
            tap      <= 2'd0;
            in_ready <= 1'b0;
            state    <= ST_MAC;
          end
        end
        ST_MAC: begin
          tap <= tap + 2'd1;
          if (tap == 2'd3) state <= ST_SAT;
        end
        ST_SAT: begin
          y         <= y_sat;
          y3        <= y2;
          y2        <= y1;
          y1        <= y_sat;
          out_valid <= 1'b1;
          sat_flag  <= sat_flag | clamped;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_allpole_3rd_order_mac.sv
// tb/tb_iir_allpole_3rd_order_mac.sv - table-driven scoreboard bench for the all-pole IIR
module tb_iir_allpole_3rd_order_mac;

  localparam int DW = 16;
  localparam int CW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 clr_state = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b1;
  logic                 in_ready, out_valid, sat_flag;
  logic signed [DW-1:0] x = '0;
  logic signed [DW-1:0] y;
  logic signed [CW-1:0] g0 = '0, a1 = '0, a2 = '0, a3 = '0;

  always #5 clk = ~clk;

  iir_allpole_3rd_order_mac #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr_state(clr_state),
    .x        (x),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .g0       (g0),
    .a1       (a1),
    .a2       (a2),
    .a3       (a3),
    .y        (y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sat_flag (sat_flag)
  );

  typedef struct {
    int y;
    bit sat;
  } exp_t;

  typedef struct {
    bit clr;
    int g0, a1, a2, a3;
    int x;
    int exp_y;
    bit exp_sat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[18];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard: every output handshake pops one expectation
  always @(negedge clk) begin
    if (!rst && !clr_state && out_valid && out_ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_output", int'(y), 0);
      end else begin
        e = sb.pop_front();
        chk(y == e.y, "y", int'(y), e.y);
        chk(sat_flag == e.sat, "sat_flag", int'(sat_flag), int'(e.sat));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk(1'b0, "in_ready_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!out_valid) chk(1'b0, "out_valid_timeout", lat, 5);
  endtask

  task automatic accept_sample(input int xv);
    wait_ready();
    x        = 16'(xv);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send(input int xv, input int ey, input bit es, input bit chk_lat);
    int lat;
    sb.push_back('{ey, es});
    accept_sample(xv);
    wait_valid(lat);
    if (chk_lat) chk(lat == 5, "latency", lat, 5);
    tick();
  endtask

  task automatic set_coeffs(input int c0, input int c1, input int c2, input int c3);
    g0 = 16'(c0);
    a1 = 16'(c1);
    a2 = 16'(c2);
    a3 = 16'(c3);
  endtask

  task automatic pulse_clr();
    clr_state = 1'b1;
    tick();
    clr_state = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic signed [DW-1:0] held;

    vecs[0]  = '{1'b1, 16384,      0,    0,     0,   1000,    500, 1'b0};
    vecs[1]  = '{1'b1, 16384, -16384,    0,     0,  20000,  10000, 1'b0};
    vecs[2]  = '{1'b0, 16384, -16384,    0,     0,      0,   5000, 1'b0};
    vecs[3]  = '{1'b0, 16384, -16384,    0,     0,      0,   2500, 1'b0};
    vecs[4]  = '{1'b0, 16384, -16384,    0,     0,      0,   1250, 1'b0};
    vecs[5]  = '{1'b0, 16384, -16384,    0,     0,      0,    625, 1'b0};
    vecs[6]  = '{1'b0, 16384, -16384,    0,     0,      0,    312, 1'b0};
    vecs[7]  = '{1'b1, 32767, -32768,    0,     0,  32767,  32766, 1'b0};
    vecs[8]  = '{1'b0, 32767, -32768,    0,     0,  32767,  32767, 1'b1};
    vecs[9]  = '{1'b0, 32767, -32768,    0,     0,  32767,  32767, 1'b1};
    vecs[10] = '{1'b1, 32767, -32768,    0,     0, -32768, -32767, 1'b0};
    vecs[11] = '{1'b0, 32767, -32768,    0,     0, -32768, -32768, 1'b1};
    vecs[12] = '{1'b1, 16384,      0, 8192, -8192,   1000,    500, 1'b0};
    vecs[13] = '{1'b0, 16384,      0, 8192, -8192,   1000,    500, 1'b0};
    vecs[14] = '{1'b0, 16384,      0, 8192, -8192,      0,   -125, 1'b0};
    vecs[15] = '{1'b0, 16384,      0, 8192, -8192,      0,      0, 1'b0};
    vecs[16] = '{1'b0, 16384,      0, 8192, -8192,      0,    156, 1'b0};
    vecs[17] = '{1'b1, 16384,      0,    0,     0,     -3,     -2, 1'b0};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk(in_ready == 1'b1, "reset_in_ready", int'(in_ready), 1);
    chk(out_valid == 1'b0, "reset_out_valid", int'(out_valid), 0);
    chk(y == 0, "reset_y", int'(y), 0);
    chk(sat_flag == 1'b0, "reset_sat_flag", int'(sat_flag), 0);

    foreach (vecs[i]) begin
      set_coeffs(vecs[i].g0, vecs[i].a1, vecs[i].a2, vecs[i].a3);
      if (vecs[i].clr) pulse_clr();
      send(vecs[i].x, vecs[i].exp_y, vecs[i].exp_sat, 1'b1);
    end

    // Saturation is sticky until cleared
    set_coeffs(32767, -32768, 0, 0);
    pulse_clr();
    send(32767, 32766, 1'b0, 1'b0);
    send(32767, 32767, 1'b1, 1'b0);
    send(0, 32767, 1'b1, 1'b0);
    pulse_clr();
    chk(sat_flag == 1'b0, "clr_sat_flag", int'(sat_flag), 0);
    chk(y == 0, "clr_y", int'(y), 0);

    // Backpressure: output held, no new accept, nothing lost on release
    set_coeffs(16384, -16384, 0, 0);
    pulse_clr();
    out_ready = 1'b0;
    sb.push_back('{10000, 1'b0});
    accept_sample(20000);
    wait_valid(lat);
    held     = y;
    x        = 16'(0);
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk(out_valid == 1'b1, "bp_out_valid", int'(out_valid), 1);
      chk(y == held, "bp_y_held", int'(y), int'(held));
      chk(in_ready == 1'b0, "bp_in_ready", int'(in_ready), 0);
    end
    sb.push_back('{5000, 1'b0});
    out_ready = 1'b1;
    tick();
    wait_ready();
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    chk(lat == 5, "bp_next_latency", lat, 5);
    tick();

    // Coefficient change mid-sample only affects the next accept
    set_coeffs(16384, -16384, 0, 0);
    pulse_clr();
    send(20000, 10000, 1'b0, 1'b0);
    sb.push_back('{5000, 1'b0});
    accept_sample(0);
    tick();
    a1 = 16'(0);
    wait_valid(lat);
    tick();
    send(0, 0, 1'b0, 1'b0);

    // clr_state wins over a simultaneous take
    out_ready = 1'b0;
    accept_sample(1000);
    wait_valid(lat);
    clr_state = 1'b1;
    out_ready = 1'b1;
    tick();
    clr_state = 1'b0;
    chk(out_valid == 1'b0, "clr_take_out_valid", int'(out_valid), 0);
    chk(y == 0, "clr_take_y", int'(y), 0);
    chk(in_ready == 1'b1, "clr_take_in_ready", int'(in_ready), 1);

    // rst during MAC discards the sample and all history
    set_coeffs(16384, -16384, 0, 0);
    pulse_clr();
    send(20000, 10000, 1'b0, 1'b0);
    send(0, 5000, 1'b0, 1'b0);
    accept_sample(20000);
    tick();
    rst = 1'b1;
    #2;
    chk(in_ready == 1'b1, "rst_mac_in_ready", int'(in_ready), 1);
    chk(out_valid == 1'b0, "rst_mac_out_valid", int'(out_valid), 0);
    chk(y == 0, "rst_mac_y", int'(y), 0);
    tick();
    rst = 1'b0;
    tick();
    for (int i = 1; i <= 6; i++) begin
      send(vecs[i].x, vecs[i].exp_y, vecs[i].exp_sat, 1'b1);
    end

    repeat (3) tick();
    chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
